// File: rtl/sys_ctrl_rx_decoder.sv
// rtl/sys_ctrl_rx_decoder.sv - command frame decoder driving register file, ALU and TX response
//
// Ports:
//   clk, reset_n                  reference clock, asynchronous active-low reset
//   rx_valid_in, rx_data_in       synchronized incoming byte stream (one-cycle pulse + held byte)
//   rf_wr_en, rf_rd_en            one-cycle register-file strobes
//   rf_addr, rf_wr_data           register-file address and write data
//   rf_rd_data_valid, rf_rd_data  register-file read return
//   alu_en, alu_fun, clk_gate_en  ALU strobe, function code and clock-gate enable
//   alu_out_valid, alu_out        ALU result return
//   tx_data_out, tx_valid_out     response bytes toward the TX synchronizer
//   tx_busy_in                    TX path busy
//
// Optional feature macro: CMD_TIMEOUT_EN (inter-byte timeout abandons partial frames).
module sys_ctrl_rx_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     rx_valid_in,
    input  logic [DATA_WIDTH-1:0]    rx_data_in,
    output logic                     rf_wr_en,
    output logic                     rf_rd_en,
    output logic [ADDR_WIDTH-1:0]    rf_addr,
    output logic [DATA_WIDTH-1:0]    rf_wr_data,
    input  logic                     rf_rd_data_valid,
    input  logic [DATA_WIDTH-1:0]    rf_rd_data,
    output logic                     alu_en,
    output logic [3:0]               alu_fun,
    output logic                     clk_gate_en,
    input  logic                     alu_out_valid,
    input  logic [ALU_OUT_WIDTH-1:0] alu_out,
    output logic [DATA_WIDTH-1:0]    tx_data_out,
    output logic                     tx_valid_out,
    input  logic                     tx_busy_in
);

    if (ALU_OUT_WIDTH != 2 * DATA_WIDTH || ADDR_WIDTH > DATA_WIDTH || TIMEOUT_CYCLES < 1) begin : g_cfg_err
        $error("sys_ctrl_rx_decoder: invalid parameter set");
    end

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
        ALU_FUN, ALU_WAIT, TX_LO, TX_HI
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic                     wr_en_q, wr_en_d;
    logic                     rd_en_q, rd_en_d;
    logic                     alu_en_q, alu_en_d;
    logic [3:0]               alu_fun_q, alu_fun_d;
    logic [ALU_OUT_WIDTH-1:0] resp_q, resp_d;
    logic                     two_byte_q, two_byte_d;
    logic                     busy_seen_q, busy_seen_d;
    logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
    logic                     tx_valid_q, tx_valid_d;
    logic                     timeout_hit;

`ifdef CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_armed;

    // Counts idle cycles only while a frame is partially received.
    always_comb begin
        tmo_armed   = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR) ||
                      (state_q == OP_A)    || (state_q == OP_B)    || (state_q == ALU_FUN);
        timeout_hit = tmo_armed && !rx_valid_in && (tmo_q == TMO_W'(TIMEOUT_CYCLES));
        tmo_d       = '0;
        if (tmo_armed && !rx_valid_in && !timeout_hit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        alu_en_d    = 1'b0;
        alu_fun_d   = alu_fun_q;
        resp_d      = resp_q;
        two_byte_d  = two_byte_q;
        busy_seen_d = busy_seen_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid_in) begin
                    case (rx_data_in)
                        CMD_WR:     state_d = WR_ADDR;
                        CMD_RD:     state_d = RD_ADDR;
                        CMD_ALU_OP: state_d = OP_A;
                        CMD_ALU:    state_d = ALU_FUN;
                        default:    state_d = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (rx_valid_in) begin
                    addr_d  = rx_data_in[ADDR_WIDTH-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (rx_valid_in) begin
                    wr_data_d = rx_data_in;
                    wr_en_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                if (rx_valid_in) begin
                    addr_d  = rx_data_in[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rf_rd_data_valid) begin
                    resp_d     = ALU_OUT_WIDTH'(rf_rd_data);
                    two_byte_d = 1'b0;
                    state_d    = TX_LO;
                end
            end
            // Operands are staged in RF locations 0 and 1, where the ALU reads them.
            OP_A: begin
                if (rx_valid_in) begin
                    addr_d    = '0;
                    wr_data_d = rx_data_in;
                    wr_en_d   = 1'b1;
                    state_d   = OP_B;
                end
            end
            OP_B: begin
                if (rx_valid_in) begin
                    addr_d    = ADDR_WIDTH'(1);
                    wr_data_d = rx_data_in;
                    wr_en_d   = 1'b1;
                    state_d   = ALU_FUN;
                end
            end
            ALU_FUN: begin
                if (rx_valid_in) begin
                    alu_fun_d = rx_data_in[3:0];
                    alu_en_d  = 1'b1;
                    state_d   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (alu_out_valid) begin
                    resp_d     = alu_out;
                    two_byte_d = 1'b1;
                    state_d    = TX_LO;
                end
            end
            TX_LO: begin
                if (!tx_busy_in) begin
                    tx_data_d   = resp_q[DATA_WIDTH-1:0];
                    tx_valid_d  = 1'b1;
                    busy_seen_d = 1'b0;
                    state_d     = two_byte_q ? TX_HI : IDLE;
                end
            end
            // The high byte waits for the TX path to acknowledge the low byte
            // with a full busy pulse, then for it to become free again.
            TX_HI: begin
                if (!busy_seen_q) begin
                    if (tx_busy_in) begin
                        busy_seen_d = 1'b1;
                    end
                end else if (!tx_busy_in) begin
                    tx_data_d   = resp_q[ALU_OUT_WIDTH-1:DATA_WIDTH];
                    tx_valid_d  = 1'b1;
                    busy_seen_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout_hit) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            alu_en_q    <= 1'b0;
            alu_fun_q   <= '0;
            resp_q      <= '0;
            two_byte_q  <= 1'b0;
            busy_seen_q <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            alu_en_q    <= alu_en_d;
            alu_fun_q   <= alu_fun_d;
            resp_q      <= resp_d;
            two_byte_q  <= two_byte_d;
            busy_seen_q <= busy_seen_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign rf_wr_en     = wr_en_q;
    assign rf_rd_en     = rd_en_q;
    assign rf_addr      = addr_q;
    assign rf_wr_data   = wr_data_q;
    assign alu_en       = alu_en_q;
    assign alu_fun      = alu_fun_q;
    // ALU clock runs from the function phase until its result has been captured.
    assign clk_gate_en  = (state_q == ALU_FUN) || (state_q == ALU_WAIT);
    assign tx_data_out  = tx_data_q;
    assign tx_valid_out = tx_valid_q;

endmodule

// File: tb/tb_sys_ctrl_rx_decoder.sv
// tb/tb_sys_ctrl_rx_decoder.sv - randomized self-checking bench for sys_ctrl_rx_decoder
module tb_sys_ctrl_rx_decoder;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_valid_in;
    logic [7:0]  rx_data_in;
    logic        rf_wr_en, rf_rd_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic        rf_rd_data_valid;
    logic [7:0]  rf_rd_data;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic        clk_gate_en;
    logic        alu_out_valid;
    logic [15:0] alu_out;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_busy_in;

    always #5 clk = ~clk;

    sys_ctrl_rx_decoder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
        .rf_rd_data_valid(rf_rd_data_valid), .rf_rd_data(rf_rd_data),
        .alu_en(alu_en), .alu_fun(alu_fun), .clk_gate_en(clk_gate_en),
        .alu_out_valid(alu_out_valid), .alu_out(alu_out),
        .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .tx_busy_in(tx_busy_in)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: register contents implied by the frames sent so far.
    logic [7:0]  ref_mem [16];
    // Environment register file, updated only from what the DUT actually writes.
    logic [7:0]  rf_env  [16];

    logic [11:0] wr_q[$], exp_wr[$];
    logic [3:0]  rd_q[$], exp_rd[$];
    logic [3:0]  alu_q[$], exp_alu[$];
    logic [7:0]  tx_q[$], exp_tx[$];

    function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            4'd1:    return 16'(a) + 16'(b);
            4'd2:    return 16'(a) - 16'(b);
            4'd3:    return 16'(a) * 16'(b);
            default: return {a, b} ^ {4{f}};
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (rf_wr_en) wr_q.push_back({rf_addr, rf_wr_data});
            if (rf_rd_en) rd_q.push_back(rf_addr);
            if (alu_en)   alu_q.push_back(alu_fun);
            if (tx_valid_out) begin
                tx_q.push_back(tx_data_out);
                check_eq("tx_while_busy", 32'(tx_busy_in), 32'd0);
            end
        end
    end

    // Register-file responder.
    initial begin
        logic [3:0] a;
        int         d;
        rf_rd_data_valid = 1'b0;
        rf_rd_data       = '0;
        for (int i = 0; i < 16; i++) rf_env[i] = '0;
        forever begin
            @(negedge clk);
            if (reset_n && rf_wr_en) rf_env[rf_addr] = rf_wr_data;
            if (reset_n && rf_rd_en) begin
                a = rf_addr;
                d = $urandom_range(1, 3);
                repeat (d) @(posedge clk);
                #1;
                rf_rd_data       = rf_env[a];
                rf_rd_data_valid = 1'b1;
                @(posedge clk);
                #1 rf_rd_data_valid = 1'b0;
            end
        end
    end

    // ALU responder; also watches the clock-gate enable around the result.
    initial begin
        logic [3:0] f;
        int         d;
        alu_out_valid = 1'b0;
        alu_out       = '0;
        forever begin
            @(negedge clk);
            if (reset_n && alu_en) begin
                f = alu_fun;
                d = $urandom_range(1, 3);
                repeat (d) @(posedge clk);
                #1;
                alu_out       = alu_ref(f, rf_env[0], rf_env[1]);
                alu_out_valid = 1'b1;
                @(negedge clk);
                check_eq("cg_at_valid", 32'(clk_gate_en), 32'd1);
                @(posedge clk);
                #1 alu_out_valid = 1'b0;
                @(negedge clk);
                check_eq("cg_after_valid", 32'(clk_gate_en), 32'd0);
            end
        end
    end

    // TX path: each emitted byte is followed by a busy pulse of random length.
    initial begin
        int d;
        tx_busy_in = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && tx_valid_out) begin
                d = $urandom_range(1, 4);
                @(posedge clk);
                #1 tx_busy_in = 1'b1;
                repeat (d) @(posedge clk);
                #1 tx_busy_in = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Drivers assume the caller sits just after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid_in = 1'b1;
        rx_data_in  = b;
        @(posedge clk);
        #1 rx_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_garbage();
        logic [7:0] b;
        do b = 8'($urandom); while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
        send_byte(b);
        idle(1);
    endtask

    task automatic clear_queues();
        wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete();
        exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_tx.delete();
    endtask

    task automatic compare_queues();
        check_eq("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
        for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) check_eq("wr_txn", 32'(wr_q[i]), 32'(exp_wr[i]));
        check_eq("rd_count", 32'(rd_q.size()), 32'(exp_rd.size()));
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) check_eq("rd_addr", 32'(rd_q[i]), 32'(exp_rd[i]));
        check_eq("alu_count", 32'(alu_q.size()), 32'(exp_alu.size()));
        for (int i = 0; i < alu_q.size() && i < exp_alu.size(); i++) check_eq("alu_fun", 32'(alu_q[i]), 32'(exp_alu[i]));
        check_eq("tx_count", 32'(tx_q.size()), 32'(exp_tx.size()));
        for (int i = 0; i < tx_q.size() && i < exp_tx.size(); i++) check_eq("tx_byte", 32'(tx_q[i]), 32'(exp_tx[i]));
    endtask

    task automatic do_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input int n, input bit inj);
        logic [7:0]  fb [4];
        logic [15:0] r;
        logic        strobe;
        int          cyc;
        fb = '{b0, b1, b2, b3};
        clear_queues();
        check_eq("cg_idle", 32'(clk_gate_en), 32'd0);
        case (b0)
            8'hAA: begin
                exp_wr.push_back({b1[3:0], b2});
                ref_mem[b1[3:0]] = b2;
            end
            8'hBB: begin
                exp_rd.push_back(b1[3:0]);
                exp_tx.push_back(ref_mem[b1[3:0]]);
            end
            8'hCC: begin
                exp_wr.push_back({4'd0, b1});
                exp_wr.push_back({4'd1, b2});
                ref_mem[0] = b1;
                ref_mem[1] = b2;
                r = alu_ref(b3[3:0], b1, b2);
                exp_alu.push_back(b3[3:0]);
                exp_tx.push_back(r[7:0]);
                exp_tx.push_back(r[15:8]);
            end
            default: begin
                r = alu_ref(b1[3:0], ref_mem[0], ref_mem[1]);
                exp_alu.push_back(b1[3:0]);
                exp_tx.push_back(r[7:0]);
                exp_tx.push_back(r[15:8]);
            end
        endcase
        for (int i = 0; i < n; i++) begin
            send_byte(fb[i]);
            if (i < n - 1) idle($urandom_range(0, 3));
        end
        // Strobe must follow the last byte by exactly one edge and last one cycle.
        @(negedge clk);
        strobe = (b0 == 8'hAA) ? rf_wr_en : (b0 == 8'hBB) ? rf_rd_en : alu_en;
        check_eq("strobe_latency", 32'(strobe), 32'd1);
        if (b0 == 8'hCC || b0 == 8'hDD) check_eq("cg_in_alu", 32'(clk_gate_en), 32'd1);
        @(negedge clk);
        strobe = (b0 == 8'hAA) ? rf_wr_en : (b0 == 8'hBB) ? rf_rd_en : alu_en;
        check_eq("strobe_one_cycle", 32'(strobe), 32'd0);
        @(posedge clk);
        #1;
        if (inj) send_byte(8'hAA);
        cyc = 0;
        while (!(tx_q.size() >= exp_tx.size() && !tx_busy_in) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) check_eq("frame_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        idle(7);
        compare_queues();
    endtask

    initial begin
        logic [7:0] b0;
        int         n;
        reset_n     = 1'b0;
        rx_valid_in = 1'b0;
        rx_data_in  = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_strobes", 32'({rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_valid_out}), 32'd0);
        check_eq("rst_rf_addr", 32'(rf_addr), 32'd0);
        check_eq("rst_rf_wr_data", 32'(rf_wr_data), 32'd0);
        check_eq("rst_alu_fun", 32'(alu_fun), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data_out), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        do_frame(8'hAA, 8'h05, 8'h3C, 8'h00, 3, 1'b0);
        do_frame(8'hAA, 8'h07, 8'h5A, 8'h00, 3, 1'b0);
        do_frame(8'hBB, 8'h07, 8'h00, 8'h00, 2, 1'b1);
        do_frame(8'hCC, 8'h12, 8'h34, 8'h01, 4, 1'b1);
        check_eq("alu_plan_lo", 32'(tx_q[0]), 32'h46);
        send_byte(8'h00);
        idle(1);
        send_byte(8'hFF);
        idle(1);
        do_frame(8'hDD, 8'h03, 8'h00, 8'h00, 2, 1'b0);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) send_garbage();
            case ($urandom_range(0, 3))
                0:       begin b0 = 8'hAA; n = 3; end
                1:       begin b0 = 8'hBB; n = 2; end
                2:       begin b0 = 8'hCC; n = 4; end
                default: begin b0 = 8'hDD; n = 2; end
            endcase
            do_frame(b0, 8'($urandom), 8'($urandom), 8'($urandom), n,
                     (b0 != 8'hAA) && ($urandom_range(0, 1) == 1));
        end

        // Asynchronous reset in the middle of a write frame.
        clear_queues();
        send_byte(8'hAA);
        idle(1);
        send_byte(8'h05);
        #3 reset_n = 1'b0;
        #1;
        check_eq("rst_mid_strobes", 32'({rf_wr_en, rf_rd_en, alu_en, clk_gate_en, tx_valid_out}), 32'd0);
        check_eq("rst_mid_rf_addr", 32'(rf_addr), 32'd0);
        check_eq("rst_mid_wr_data", 32'(rf_wr_data), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);
        send_byte(8'h3C);
        idle(5);
        check_eq("rst_no_write", 32'(wr_q.size()), 32'd0);
        do_frame(8'hAA, 8'h05, 8'h3C, 8'h00, 3, 1'b0);

        // Long pause inside a partial frame.
        clear_queues();
        send_byte(8'hAA);
        idle(1);
        send_byte(8'h05);
`ifdef CMD_TIMEOUT_EN
        idle(TMO + 10);
        send_byte(8'h3C);
        idle(5);
        check_eq("tmo_no_write", 32'(wr_q.size()), 32'd0);
`else
        idle(200);
        send_byte(8'h3C);
        idle(3);
        check_eq("no_tmo_write_cnt", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) check_eq("no_tmo_write_val", 32'(wr_q[0]), 32'h53C);
        ref_mem[5] = 8'h3C;
`endif
        do_frame(8'hBB, 8'h05, 8'h00, 8'h00, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
